// File: rtl/etapa_id_ex.sv
// ID/EX pipeline register with MEM/WB operand bypass and PC/imm operand select.
// Ports: decode handshake (id_*), flush, ex_listo, mem_*/wb_* bypass, ALU operands and held fields; FORWARDING_EN enables bypass.
module etapa_id_ex #(
  parameter int ANCHO     = 32,
  parameter int ANCHO_REG = 5,
  parameter int ANCHO_OP  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valido,
  output logic                 id_listo,
  input  logic [ANCHO-1:0]     id_pc,
  input  logic [ANCHO_REG-1:0] id_rs1,
  input  logic [ANCHO_REG-1:0] id_rs2,
  input  logic [ANCHO-1:0]     id_rs1_dato,
  input  logic [ANCHO-1:0]     id_rs2_dato,
  input  logic [ANCHO-1:0]     id_imm,
  input  logic                 id_usa_pc,
  input  logic                 id_usa_imm,
  input  logic [ANCHO_OP-1:0]  id_operacion,
  input  logic [ANCHO_REG-1:0] id_rd,
  input  logic                 id_escribe_rd,
  input  logic                 flush,
  input  logic                 ex_listo,
  input  logic                 mem_escribe,
  input  logic [ANCHO_REG-1:0] mem_rd,
  input  logic [ANCHO-1:0]     mem_dato,
  input  logic                 wb_escribe,
  input  logic [ANCHO_REG-1:0] wb_rd,
  input  logic [ANCHO-1:0]     wb_dato,
  output logic                 ex_valido,
  output logic [ANCHO-1:0]     valA,
  output logic [ANCHO-1:0]     valB,
  output logic [ANCHO_OP-1:0]  operacion,
  output logic [ANCHO-1:0]     ex_rs2_dato,
  output logic [ANCHO-1:0]     ex_pc,
  output logic [ANCHO_REG-1:0] ex_rd,
  output logic                 ex_escribe_rd
);

  logic                 r_valido;
  logic [ANCHO-1:0]     r_pc;
  logic [ANCHO_REG-1:0] r_rs1;
  logic [ANCHO_REG-1:0] r_rs2;
  logic [ANCHO-1:0]     r_rs1_dato;
  logic [ANCHO-1:0]     r_rs2_dato;
  logic [ANCHO-1:0]     r_imm;
  logic                 r_usa_pc;
  logic                 r_usa_imm;
  logic [ANCHO_OP-1:0]  r_op;
  logic [ANCHO_REG-1:0] r_rd;
  logic                 r_escribe;

  logic                 w_carga;
  logic [ANCHO-1:0]     w_fwd1;
  logic [ANCHO-1:0]     w_fwd2;

  assign id_listo = !r_valido || ex_listo;
  assign w_carga  = id_valido && id_listo;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valido   <= 1'b0;
      r_pc       <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rs1_dato <= '0;
      r_rs2_dato <= '0;
      r_imm      <= '0;
      r_usa_pc   <= 1'b0;
      r_usa_imm  <= 1'b0;
      r_op       <= '0;
      r_rd       <= '0;
      r_escribe  <= 1'b0;
    end else if (flush) begin
      r_valido <= 1'b0;
    end else if (w_carga) begin
      r_valido   <= 1'b1;
      r_pc       <= id_pc;
      r_rs1      <= id_rs1;
      r_rs2      <= id_rs2;
      r_rs1_dato <= id_rs1_dato;
      r_rs2_dato <= id_rs2_dato;
      r_imm      <= id_imm;
      r_usa_pc   <= id_usa_pc;
      r_usa_imm  <= id_usa_imm;
      r_op       <= id_operacion;
      r_rd       <= id_rd;
      r_escribe  <= id_escribe_rd;
    end else if (r_valido && ex_listo) begin
      r_valido <= 1'b0;
    end
  end

`ifdef FORWARDING_EN
  // x0 is never bypassed; MEM is younger than WB so it wins.
  always_comb begin
    w_fwd1 = r_rs1_dato;
    if (r_rs1 != '0) begin
      if (mem_escribe && mem_rd == r_rs1)
        w_fwd1 = mem_dato;
      else if (wb_escribe && wb_rd == r_rs1)
        w_fwd1 = wb_dato;
    end
  end

  always_comb begin
    w_fwd2 = r_rs2_dato;
    if (r_rs2 != '0) begin
      if (mem_escribe && mem_rd == r_rs2)
        w_fwd2 = mem_dato;
      else if (wb_escribe && wb_rd == r_rs2)
        w_fwd2 = wb_dato;
    end
  end
`else
  logic w_bypass_nc;
  assign w_bypass_nc = ^{mem_escribe, mem_rd, mem_dato,
                         wb_escribe, wb_rd, wb_dato};
  assign w_fwd1 = r_rs1_dato;
  assign w_fwd2 = r_rs2_dato;
`endif

  assign ex_valido     = r_valido;
  assign valA          = r_usa_pc ? r_pc : w_fwd1;
  assign valB          = r_usa_imm ? r_imm : w_fwd2;
  assign ex_rs2_dato   = w_fwd2;
  assign operacion     = r_op;
  assign ex_pc         = r_pc;
  assign ex_rd         = r_rd;
  assign ex_escribe_rd = r_escribe && r_valido;

endmodule

// File: tb/tb_etapa_id_ex.sv
// Directed bench for etapa_id_ex: vector table plus reset, bypass and stall sequences.
// Expected bypass results follow whether FORWARDING_EN is defined.
module tb_etapa_id_ex;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valido;
  logic        id_listo;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1, id_rs2;
  logic [31:0] id_rs1_dato, id_rs2_dato, id_imm;
  logic        id_usa_pc, id_usa_imm;
  logic [3:0]  id_operacion;
  logic [4:0]  id_rd;
  logic        id_escribe_rd;
  logic        flush, ex_listo;
  logic        mem_escribe, wb_escribe;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_dato, wb_dato;
  logic        ex_valido;
  logic [31:0] valA, valB, ex_rs2_dato, ex_pc;
  logic [3:0]  operacion;
  logic [4:0]  ex_rd;
  logic        ex_escribe_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  etapa_id_ex dut (
    .clk(clk), .rst(rst),
    .id_valido(id_valido), .id_listo(id_listo),
    .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_dato(id_rs1_dato), .id_rs2_dato(id_rs2_dato),
    .id_imm(id_imm), .id_usa_pc(id_usa_pc), .id_usa_imm(id_usa_imm),
    .id_operacion(id_operacion), .id_rd(id_rd),
    .id_escribe_rd(id_escribe_rd), .flush(flush), .ex_listo(ex_listo),
    .mem_escribe(mem_escribe), .mem_rd(mem_rd), .mem_dato(mem_dato),
    .wb_escribe(wb_escribe), .wb_rd(wb_rd), .wb_dato(wb_dato),
    .ex_valido(ex_valido), .valA(valA), .valB(valB),
    .operacion(operacion), .ex_rs2_dato(ex_rs2_dato), .ex_pc(ex_pc),
    .ex_rd(ex_rd), .ex_escribe_rd(ex_escribe_rd)
  );

  typedef struct {
    logic        vld;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2;
    logic [31:0] d1, d2, imm;
    logic        upc, uimm;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        wr, fl, exl;
    logic        ev;
    logic [31:0] a, b;
    logic [3:0]  eop;
    logic [31:0] s2;
    logic [4:0]  erd;
    logic        ewr, listo;
  } vec_t;

  vec_t v[10];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    id_valido     = t.vld;
    id_pc         = t.pc;
    id_rs1        = t.rs1;
    id_rs2        = t.rs2;
    id_rs1_dato   = t.d1;
    id_rs2_dato   = t.d2;
    id_imm        = t.imm;
    id_usa_pc     = t.upc;
    id_usa_imm    = t.uimm;
    id_operacion  = t.op;
    id_rd         = t.rd;
    id_escribe_rd = t.wr;
    flush         = t.fl;
    ex_listo      = t.exl;
  endtask

  logic [31:0] exp_fa;

  initial begin
    //      vld pc rs1 rs2 d1 d2 imm upc uimm op rd wr fl exl |
    //      ev a b op s2 rd ewr listo
    v[0] = '{1, 32'h0, 1, 2, 5, 7, 0, 0, 0, 4'h0, 3, 1, 0, 1,
             1, 5, 7, 4'h0, 7, 3, 1, 1};
    v[1] = '{1, 32'h4, 4, 5, 100, 30, 32'h10, 0, 1, 4'h1, 6, 1, 0, 1,
             1, 100, 32'h10, 4'h1, 30, 6, 1, 1};
    v[2] = '{1, 32'h100, 0, 7, 0, 32'h55, 32'h2000, 1, 1, 4'h0, 8, 1, 0, 1,
             1, 32'h100, 32'h2000, 4'h0, 32'h55, 8, 1, 1};
    v[3] = '{0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 1,
             0, 32'h100, 32'h2000, 4'h0, 32'h55, 8, 0, 1};
    v[4] = '{1, 32'h8, 9, 10, 32'h80000000, 4, 0, 0, 0, 4'hD, 0, 0, 0, 1,
             1, 32'h80000000, 4, 4'hD, 4, 0, 0, 1};
    v[5] = '{1, 32'hC, 11, 12, 32'h11, 32'h22, 0, 0, 0, 4'h2, 13, 1, 1, 1,
             0, 32'h80000000, 4, 4'hD, 4, 0, 0, 1};
    v[6] = '{1, 32'h40, 1, 2, 32'hDEAD, 32'hBEEF, 0, 0, 0, 4'h5, 31, 1, 0, 0,
             1, 32'hDEAD, 32'hBEEF, 4'h5, 32'hBEEF, 31, 1, 0};
    v[7] = '{1, 32'h44, 3, 4, 1, 2, 0, 0, 0, 4'h7, 1, 1, 0, 0,
             1, 32'hDEAD, 32'hBEEF, 4'h5, 32'hBEEF, 31, 1, 0};
    v[8] = v[7];
    v[9] = '{1, 32'h44, 3, 4, 1, 2, 0, 0, 0, 4'h7, 1, 1, 0, 1,
             1, 1, 2, 4'h7, 2, 1, 1, 1};

    rst = 1'b1;
    drive(v[3]);
    mem_escribe = 0; mem_rd = 0; mem_dato = 0;
    wb_escribe = 0;  wb_rd = 0;  wb_dato = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_valido", {31'b0, ex_valido}, 0);
    chk("rst_valA", valA, 0);
    chk("rst_valB", valB, 0);
    chk("rst_op", {28'b0, operacion}, 0);
    chk("rst_pc", ex_pc, 0);
    chk("rst_ewr", {31'b0, ex_escribe_rd}, 0);
    chk("rst_listo", {31'b0, id_listo}, 1);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(v[i]);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valido", i), {31'b0, ex_valido}, {31'b0, v[i].ev});
      chk($sformatf("v%0d_valA", i), valA, v[i].a);
      chk($sformatf("v%0d_valB", i), valB, v[i].b);
      chk($sformatf("v%0d_op", i), {28'b0, operacion}, {28'b0, v[i].eop});
      chk($sformatf("v%0d_rs2", i), ex_rs2_dato, v[i].s2);
      chk($sformatf("v%0d_rd", i), {27'b0, ex_rd}, {27'b0, v[i].erd});
      chk($sformatf("v%0d_ewr", i), {31'b0, ex_escribe_rd}, {31'b0, v[i].ewr});
      chk($sformatf("v%0d_listo", i), {31'b0, id_listo}, {31'b0, v[i].listo});
    end

    // Bypass on a stalled instruction: rs1=x3 (1), rs2=x0 (0x33).
    @(negedge clk);
    drive('{1, 32'h60, 3, 0, 1, 32'h33, 0, 0, 0, 4'h0, 4, 1, 0, 1,
            0, 0, 0, 4'h0, 0, 0, 0, 0});
    @(posedge clk);
    #1;
    id_valido = 0;
    ex_listo  = 0;
    mem_escribe = 1; mem_rd = 3; mem_dato = 32'hAA;
    wb_escribe  = 1; wb_rd  = 3; wb_dato  = 32'hBB;
    #1;
`ifdef FORWARDING_EN
    exp_fa = 32'hAA;
`else
    exp_fa = 32'h1;
`endif
    chk("fwd_mem_over_wb", valA, exp_fa);
    mem_escribe = 0;
    #1;
`ifdef FORWARDING_EN
    exp_fa = 32'hBB;
`else
    exp_fa = 32'h1;
`endif
    chk("fwd_wb", valA, exp_fa);
    wb_escribe = 0;
    mem_escribe = 1; mem_rd = 0; mem_dato = 32'hFF;
    wb_escribe  = 1; wb_rd  = 0; wb_dato  = 32'hEE;
    #1;
    chk("fwd_x0_valB", valB, 32'h33);
    chk("fwd_x0_rs2", ex_rs2_dato, 32'h33);
    mem_escribe = 0; wb_escribe = 0;
    @(posedge clk);
    #1;
    chk("fwd_held_kept", valA, 32'h1);
    chk("fwd_stall_valido", {31'b0, ex_valido}, 1);

    // Store data follows rs2 bypass even when valB is the immediate.
    @(negedge clk);
    ex_listo = 1;
    drive('{1, 32'h70, 0, 5, 0, 9, 32'h1234, 0, 1, 4'h0, 0, 0, 0, 1,
            0, 0, 0, 4'h0, 0, 0, 0, 0});
    @(posedge clk);
    #1;
    id_valido = 0;
    ex_listo  = 0;
    wb_escribe = 1; wb_rd = 5; wb_dato = 32'h77;
    #1;
`ifdef FORWARDING_EN
    exp_fa = 32'h77;
`else
    exp_fa = 32'h9;
`endif
    chk("st_rs2_fwd", ex_rs2_dato, exp_fa);
    chk("st_valB_imm", valB, 32'h1234);
    chk("st_ewr", {31'b0, ex_escribe_rd}, 0);
    wb_escribe = 0;

    // Drain: transfer out with no new input clears valid.
    @(negedge clk);
    ex_listo = 1;
    @(posedge clk);
    #1;
    chk("drain_valido", {31'b0, ex_valido}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
